// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: double-buffered three-channel PWM stage driving active-low RGB LED pins
module rgb_pwm_driver #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 47
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] r_level,
  input  logic [WIDTH-1:0] g_level,
  input  logic [WIDTH-1:0] b_level,
  input  logic             level_valid,
  output logic             level_ready,
  output logic             period_start,
  output logic             RGB_R,
  output logic             RGB_G,
  output logic             RGB_B
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] C_LAST = WIDTH'((2 ** WIDTH) - 2);

  logic [PW-1:0]    r_pre;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_act_r, r_act_g, r_act_b;
  logic [WIDTH-1:0] r_pend_r, r_pend_g, r_pend_b;
  logic             r_pend_full;
  logic             r_period_start;
  logic [2:0]       r_pins;
  logic             w_step, w_wrap, w_xfer;

  assign w_step       = r_pre == P_LAST;
  assign w_wrap       = w_step && (r_cnt == C_LAST);
  assign w_xfer       = level_valid && !r_pend_full;
  assign level_ready  = !r_pend_full;
  assign period_start = r_period_start;
  assign {RGB_R, RGB_G, RGB_B} = r_pins;

  // prescaler: one step strobe every CLK_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pre <= '0;
    else        r_pre <= w_step ? '0 : r_pre + 1'b1;
  end

  // pwm counter: 0..2^WIDTH-2, so full-scale level keeps the pin low all period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= w_wrap ? '0 : (w_step ? r_cnt + 1'b1 : r_cnt);
  end

  // pending buffer: a transfer fills it, the wrap edge empties it into active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_r    <= '0;
      r_pend_g    <= '0;
      r_pend_b    <= '0;
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend_r    <= r_level;
      r_pend_g    <= g_level;
      r_pend_b    <= b_level;
      r_pend_full <= 1'b1;
    end else if (w_wrap) begin
      r_pend_full <= 1'b0;
    end
  end

  // active levels change only at a period boundary so no period is ever cut short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act_r <= '0;
      r_act_g <= '0;
      r_act_b <= '0;
    end else if (w_wrap && r_pend_full) begin
      r_act_r <= r_pend_r;
      r_act_g <= r_pend_g;
      r_act_b <= r_pend_b;
    end
  end

  // period_start: registered marker for the cycle after each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_period_start <= 1'b0;
    else        r_period_start <= w_wrap;
  end

  // pins: registered compare keeps outputs glitch-free; low means LED on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pins <= 3'b111;
    else        r_pins <= {~(r_cnt < r_act_r), ~(r_cnt < r_act_g), ~(r_cnt < r_act_b)};
  end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed vector bench for the PWM driver at CLK_DIV=2 and CLK_DIV=1
module tb_rgb_pwm_driver;
  typedef struct {
    logic [7:0] r, g, b;
    int         er, eg, eb;
  } vec_t;

  logic       clk;
  logic       rst_n, level_valid, level_ready, period_start, RGB_R, RGB_G, RGB_B;
  logic [7:0] r_level, g_level, b_level;
  logic       rst1_n, lv1, rdy1, ps1, pr1, pg1, pb1;
  logic [7:0] r1, g1, b1;
  logic [23:0] q[$];
  int nvec = 0;
  int nmis = 0;

  rgb_pwm_driver #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .r_level(r_level), .g_level(g_level), .b_level(b_level),
    .level_valid(level_valid), .level_ready(level_ready), .period_start(period_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  rgb_pwm_driver #(.WIDTH(8), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .r_level(r1), .g_level(g1), .b_level(b1),
    .level_valid(lv1), .level_ready(rdy1), .period_start(ps1),
    .RGB_R(pr1), .RGB_G(pg1), .RGB_B(pb1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    logic pr;
    pr = level_ready;
    @(posedge clk);
    #1;
    if (level_valid && pr) begin
      if (q.size() > 0) {r_level, g_level, b_level} = q.pop_front();
      else level_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    q.push_back({r, g, b});
    if (!level_valid) begin
      {r_level, g_level, b_level} = q.pop_front();
      level_valid = 1'b1;
    end
  endtask

  task automatic measure(input int n, output int lr, output int lg, output int lb,
                         output int ps, output int rl);
    lr = 0; lg = 0; lb = 0; ps = 0; rl = 0;
    repeat (n) begin
      tick();
      if (!RGB_R) lr++;
      if (!RGB_G) lg++;
      if (!RGB_B) lb++;
      if (period_start) ps++;
      if (!level_ready) rl++;
    end
  endtask

  task automatic period(input string tag, input int er, input int eg, input int eb, input int erl);
    int lr, lg, lb, ps, rl;
    measure(510, lr, lg, lb, ps, rl);
    check({tag, " R low clocks"}, lr, er);
    check({tag, " G low clocks"}, lg, eg);
    check({tag, " B low clocks"}, lb, eb);
    check({tag, " period_start pulses"}, ps, 1);
    check({tag, " ready-low clocks"}, rl, erl);
    check({tag, " period_start at wrap"}, period_start, 1);
  endtask

  initial begin
    vec_t v[5];
    int lr, lg, lb, ps, rl, n, pos;
    v[0] = '{8'd128, 8'd0,   8'd255, 256, 0,   510};
    v[1] = '{8'd1,   8'd254, 8'd3,   2,   508, 6};
    v[2] = '{8'd255, 8'd100, 8'd50,  510, 200, 100};
    v[3] = '{8'd0,   8'd0,   8'd0,   0,   0,   0};
    v[4] = '{8'd17,  8'd85,  8'd170, 34,  170, 340};
    rst_n = 1'b0; level_valid = 1'b0; r_level = '0; g_level = '0; b_level = '0;
    rst1_n = 1'b0; lv1 = 1'b0; r1 = '0; g1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset RGB_R", RGB_R, 1);
    check("reset RGB_G", RGB_G, 1);
    check("reset RGB_B", RGB_B, 1);
    check("reset level_ready", level_ready, 1);
    check("reset period_start", period_start, 0);
    rst_n = 1'b1;
    period("idle p1", 0, 0, 0, 0);
    period("idle p2", 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      send(v[i].r, v[i].g, v[i].b);
      if (i == 0) period($sformatf("v%0d old", i), 0, 0, 0, 509);
      else period($sformatf("v%0d old", i), v[i-1].er, v[i-1].eg, v[i-1].eb, 509);
      check($sformatf("v%0d ready after commit", i), level_ready, 1);
      period($sformatf("v%0d new", i), v[i].er, v[i].eg, v[i].eb, 0);
    end
    send(8'd10, 8'd20, 8'd30);
    send(8'd200, 8'd40, 8'd60);
    period("b2b old", 34, 170, 340, 509);
    check("b2b B still offered", level_valid, 1);
    period("b2b A", 20, 40, 60, 509);
    check("b2b B accepted", level_valid, 0);
    period("b2b B", 400, 80, 120, 0);
    measure(509, lr, lg, lb, ps, rl);
    check("wrapx no early pulse", ps, 0);
    send(8'd50, 8'd150, 8'd250);
    measure(1, lr, lg, lb, ps, rl);
    check("wrapx pulse", ps, 1);
    check("wrapx ready low", level_ready, 0);
    period("wrapx old", 400, 80, 120, 509);
    period("wrapx new", 100, 300, 500, 0);
    send(8'd200, 8'd5, 8'd5);
    period("rst prep", 100, 300, 500, 509);
    send(8'd9, 8'd9, 8'd9);
    measure(100, lr, lg, lb, ps, rl);
    check("rst pre RGB_R", RGB_R, 0);
    check("rst pre ready", level_ready, 0);
    #2;
    rst_n = 1'b0;
    q.delete();
    level_valid = 1'b0;
    #1;
    check("async rst RGB_R", RGB_R, 1);
    check("async rst RGB_G", RGB_G, 1);
    check("async rst RGB_B", RGB_B, 1);
    check("async rst ready", level_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    period("post rst p1", 0, 0, 0, 0);
    period("post rst p2", 0, 0, 0, 0);
    rst1_n = 1'b1;
    lv1 = 1'b1;
    r1 = 8'd1;
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        lv1 = 1'b0;
        check("div1 ready low", rdy1, 0);
      end
      if (ps1) break;
    end
    check("div1 first wrap clocks", n, 255);
    lr = 0; lg = 0; lb = 0; ps = 0; pos = 0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk);
      #1;
      if (!pr1) begin
        lr++;
        pos = i;
      end
      if (!pg1) lg++;
      if (!pb1) lb++;
      if (ps1) ps++;
    end
    check("div1 R low clocks", lr, 1);
    check("div1 R low position", pos, 1);
    check("div1 G low clocks", lg, 0);
    check("div1 B low clocks", lb, 0);
    check("div1 period_start pulses", ps, 1);
    check("div1 ready after commit", rdy1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
